// File: rtl/alu_seq.sv
// alu_seq
// Multi-cycle ALU for the Y86-64 execute stage. It computes ADD, SUB, AND
// and XOR on WIDTH-bit two's-complement operands. ADD and SUB work through
// CHUNK bits per clock, lowest slice first, and keep the carry in a register
// between slices. AND and XOR finish in one cycle. It also produces the Y86
// condition codes ZF/SF/OF.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  request valid; sampled only while in_ready is high
//   in_ready  high only while idle
//   op        00=ADD (a+b), 01=SUB (a-b), 10=AND, 11=XOR
//   a, b      WIDTH-bit signed operands
//   out_valid result and flags valid; held until out_ready is seen
//   out_ready consumer takes the result
//   result    WIDTH-bit result, wraps modulo 2^WIDTH
//   zf        result == 0
//   sf        result MSB
//   of        signed overflow for ADD/SUB, 0 for AND/XOR
//   busy      high while an operation is running or waiting to be taken
module alu_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             busy
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } stateT;

   stateT            state;
   stateT            nextState;
   logic [1:0]       opReg;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic             carry;
   logic [CW-1:0]    sliceCnt;
   logic [CHUNK:0]   sliceSum;
   logic [WIDTH-1:0] nextResult;
   logic             isArith;
   logic             lastSlice;
   logic             finishing;

   // Handshake outputs come straight from the state register. This keeps
   // in_valid and out_ready from having any combinational path to them.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign isArith   = ~opReg[1];
   assign lastSlice = (sliceCnt == CW'(N - 1));
   assign finishing = (state == RUN) && (nextState == DONE);

   // Datapath for one RUN cycle. ADD/SUB add the current slice of a and the
   // pre-conditioned b, plus the stored carry. The sum is placed into a copy
   // of the partly built result. AND/XOR produce the whole word at once.
   // The merged word is what gets stored. On the final cycle it is also the
   // word the flags are computed from.
   always_comb begin
      sliceSum   = {1'b0, aReg[sliceCnt*CHUNK +: CHUNK]}
                 + {1'b0, bReg[sliceCnt*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry};
      nextResult = result;
      case (opReg)
         OP_AND:  nextResult = aReg & bReg;
         OP_XOR:  nextResult = aReg ^ bReg;
         default: nextResult[sliceCnt*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
      endcase
   end

   // State register. Reset drops any operation in flight and returns to
   // IDLE, so an aborted request never produces an out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. Requests are taken only in IDLE, so in_valid is
   // ignored in RUN and DONE. Arithmetic stays in RUN until the top slice
   // is done; logic ops leave RUN after one cycle. DONE waits for
   // out_ready and goes back to IDLE. It never accepts a new request on
   // that same edge.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (in_valid) nextState = RUN;
         RUN:  if (!isArith || lastSlice) nextState = DONE;
         DONE: if (out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand capture and result/flag registers. For SUB we store ~b and
   // start the carry at 1, so the slice adder always computes a + b' + c.
   // Because b was inverted, the SUB overflow test "a and b signs differ"
   // becomes "a and ~b signs match". That is the same form as the ADD
   // test, so one expression covers both. In IDLE and DONE, result and
   // flags are left alone. A finished result stays visible until the next
   // operation starts writing over it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opReg    <= OP_ADD;
         aReg     <= '0;
         bReg     <= '0;
         carry    <= 1'b0;
         sliceCnt <= '0;
         result   <= '0;
         zf       <= 1'b0;
         sf       <= 1'b0;
         of       <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) begin
            opReg    <= op;
            aReg     <= a;
            bReg     <= (op == OP_SUB) ? ~b : b;
            carry    <= (op == OP_SUB);
            sliceCnt <= '0;
         end
         if (state == RUN) begin
            result <= nextResult;
            carry  <= sliceSum[CHUNK];
            if (isArith && !lastSlice) begin
               sliceCnt <= sliceCnt + 1'b1;
            end
         end
         if (finishing) begin
            zf <= (nextResult == '0);
            sf <= nextResult[WIDTH-1];
            of <= isArith && (aReg[WIDTH-1] == bReg[WIDTH-1])
                          && (nextResult[WIDTH-1] != aReg[WIDTH-1]);
         end
      end
   end

endmodule
